instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage of the 8-bit model CPU: program counter, instruction register and
// the IDLE/FETCH/EXEC/HALTED sequencer that hands each byte to the decoder.
module instruction_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              mem_ready,
    output logic [7:0]        ir,
    output logic              EN,
    input  logic              exec_done,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              HALT,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;

    // State, PC and IR registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= {ADDR_W{1'b0}};
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, PC and IR update; inputs are only honoured in their own state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    // A jump together with HALT still loads the target before halting
                    if (jump_taken) begin
                        pc_d = jump_addr;
                    end else begin
                        pc_d = pc_q;
                    end
                    if (HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control outputs decode the registered state only
    always_comb begin
        mem_rd = 1'b0;
        EN     = 1'b0;
        halted = 1'b0;
        case (state_q)
            ST_FETCH:  mem_rd = 1'b1;
            ST_EXEC:   EN     = 1'b1;
            ST_HALTED: halted = 1'b1;
            default: begin
                mem_rd = 1'b0;
                EN     = 1'b0;
                halted = 1'b0;
            end
        endcase
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: bench-owned program memory and a
// scoreboard of expected instruction bytes checked when EN presents them.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic [7:0] ir;
    logic       EN;
    logic       exec_done;
    logic       jump_taken;
    logic [7:0] jump_addr;
    logic       HALT;
    logic [7:0] pc;
    logic       halted;

    logic [7:0] mem [0:255];
    logic [7:0] sb_q [$];
    logic [7:0] exp_ir;
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    instruction_fetch #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .EN         (EN),
        .exec_done  (exec_done),
        .jump_taken (jump_taken),
        .jump_addr  (jump_addr),
        .HALT       (HALT),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; exec_done = 1'b1;
        jump_taken = 1'b0; jump_addr = 8'h00; HALT = 1'b0;
        repeat (3) tick();
        n_total++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); else n_pass++;
        n_total++; if (EN !== 1'b0) $display("FAIL rst_en: got %b expected 0", EN); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b expected 0", halted); else n_pass++;
        n_total++; if (ir !== 8'h00) $display("FAIL rst_ir: got %h expected 00", ir); else n_pass++;
        n_total++; if (pc !== 8'h00) $display("FAIL rst_pc: got %h expected 00", pc); else n_pass++;
        n_total++; if (mem_addr !== 8'h00) $display("FAIL rst_mem_addr: got %h expected 00", mem_addr); else n_pass++;
        rst = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
        n_total++; if (mem_rd !== 1'b0) $display("FAIL idle_mem_rd: got %b expected 0", mem_rd); else n_pass++;
        tick();
        n_total++; if (mem_rd !== 1'b1) $display("FAIL first_fetch_rd: got %b expected 1", mem_rd); else n_pass++;
        n_total++; if (mem_addr !== 8'h00) $display("FAIL first_fetch_addr: got %h expected 00", mem_addr); else n_pass++;
    endtask

    task automatic test_zero_wait();
        mem[8'h00] = 8'h90; mem[8'h01] = 8'h60;
        mem_ready = 1'b1; exec_done = 1'b1;
        sb_q.push_back(8'h90);
        tick();
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir || EN !== 1'b1) $display("FAIL stream_ir0: got ir=%h EN=%b expected ir=%h EN=1", ir, EN, exp_ir); else n_pass++;
        n_total++; if (pc !== 8'h01 || mem_rd !== 1'b0) $display("FAIL stream_pc1: got pc=%h rd=%b expected pc=01 rd=0", pc, mem_rd); else n_pass++;
        sb_q.push_back(8'h60);
        tick();
        n_total++; if (mem_rd !== 1'b1 || EN !== 1'b0 || mem_addr !== 8'h01) $display("FAIL stream_fetch1: got rd=%b EN=%b addr=%h expected rd=1 EN=0 addr=01", mem_rd, EN, mem_addr); else n_pass++;
        tick();
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir || EN !== 1'b1 || pc !== 8'h02) $display("FAIL stream_ir1: got ir=%h EN=%b pc=%h expected ir=%h EN=1 pc=02", ir, EN, pc, exp_ir); else n_pass++;
        // redirect to 0x05 for the wait-state test
        jump_taken = 1'b1; jump_addr = 8'h05; mem_ready = 1'b0;
        tick();
        jump_taken = 1'b0; exec_done = 1'b0;
    endtask

    task automatic test_wait_states();
        mem[8'h05] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (mem_rd !== 1'b1 || mem_addr !== 8'h05 || ir !== 8'h60)
                $display("FAIL wait_cycle%0d: got rd=%b addr=%h ir=%h expected rd=1 addr=05 ir=60", i, mem_rd, mem_addr, ir);
            else n_pass++;
            if (i == 3) begin
                mem_ready = 1'b1;
                sb_q.push_back(8'hA5);
            end
            tick();
        end
        mem_ready = 1'b0;
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir || EN !== 1'b1 || pc !== 8'h06) $display("FAIL wait_ir: got ir=%h EN=%b pc=%h expected ir=%h EN=1 pc=06", ir, EN, pc, exp_ir); else n_pass++;
        mem_ready = 1'b1;
        tick();
        n_total++; if (EN !== 1'b1) $display("FAIL exec_hold2: got EN=%b expected 1", EN); else n_pass++;
        mem_ready = 1'b0;
        tick();
        n_total++; if (EN !== 1'b1 || ir !== 8'hA5 || pc !== 8'h06) $display("FAIL exec_hold3: got EN=%b ir=%h pc=%h expected EN=1 ir=a5 pc=06", EN, ir, pc); else n_pass++;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        n_total++; if (EN !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h06) $display("FAIL exec_release: got EN=%b rd=%b addr=%h expected EN=0 rd=1 addr=06", EN, mem_rd, mem_addr); else n_pass++;
    endtask

    task automatic test_jump();
        mem[8'h06] = 8'h00; mem[8'h10] = 8'h30;
        mem_ready = 1'b1; sb_q.push_back(8'h00);
        tick();
        mem_ready = 1'b0;
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir) $display("FAIL jump_pre_ir: got %h expected %h", ir, exp_ir); else n_pass++;
        jump_taken = 1'b1; jump_addr = 8'h77;
        tick();
        n_total++; if (pc !== 8'h07 || EN !== 1'b1) $display("FAIL jump_unqualified: got pc=%h EN=%b expected pc=07 EN=1", pc, EN); else n_pass++;
        exec_done = 1'b1; jump_addr = 8'h10;
        tick();
        exec_done = 1'b0; jump_taken = 1'b0;
        n_total++; if (mem_addr !== 8'h10 || mem_rd !== 1'b1) $display("FAIL jump_to10: got addr=%h rd=%b expected addr=10 rd=1", mem_addr, mem_rd); else n_pass++;
        mem_ready = 1'b1; sb_q.push_back(8'h30);
        tick();
        mem_ready = 1'b0;
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir || pc !== 8'h11) $display("FAIL jump_ir30: got ir=%h pc=%h expected ir=%h pc=11", ir, pc, exp_ir); else n_pass++;
        exec_done = 1'b1; jump_taken = 1'b1; jump_addr = 8'h40;
        tick();
        exec_done = 1'b0; jump_taken = 1'b0;
        n_total++; if (mem_addr !== 8'h40 || mem_rd !== 1'b1) $display("FAIL jump_to40: got addr=%h rd=%b expected addr=40 rd=1", mem_addr, mem_rd); else n_pass++;
    endtask

    task automatic test_halt_wrap();
        mem[8'h40] = 8'h01; mem[8'hFF] = 8'h70; mem[8'h00] = 8'h80;
        mem_ready = 1'b1; sb_q.push_back(8'h01);
        tick();
        mem_ready = 1'b0;
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir) $display("FAIL hw_pre_ir: got %h expected %h", ir, exp_ir); else n_pass++;
        exec_done = 1'b1; jump_taken = 1'b1; jump_addr = 8'hFF;
        tick();
        exec_done = 1'b0; jump_taken = 1'b0;
        n_total++; if (mem_addr !== 8'hFF) $display("FAIL hw_addr_ff: got %h expected ff", mem_addr); else n_pass++;
        mem_ready = 1'b1; sb_q.push_back(8'h70);
        tick();
        mem_ready = 1'b0;
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir || pc !== 8'h00) $display("FAIL hw_wrap: got ir=%h pc=%h expected ir=%h pc=00", ir, pc, exp_ir); else n_pass++;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        mem_ready = 1'b1; sb_q.push_back(8'h80);
        tick();
        mem_ready = 1'b0;
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir || pc !== 8'h01) $display("FAIL hw_ir80: got ir=%h pc=%h expected ir=%h pc=01", ir, pc, exp_ir); else n_pass++;
        exec_done = 1'b1; HALT = 1'b1; jump_taken = 1'b1; jump_addr = 8'h22;
        tick();
        HALT = 1'b0; jump_taken = 1'b0; jump_addr = 8'h55;
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (halted !== 1'b1 || mem_rd !== 1'b0 || EN !== 1'b0 || pc !== 8'h22)
                $display("FAIL halted_cycle%0d: got halted=%b rd=%b EN=%b pc=%h expected halted=1 rd=0 EN=0 pc=22", i, halted, mem_rd, EN, pc);
            else n_pass++;
            tick();
        end
        mem_ready = 1'b0; exec_done = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        mem[8'h00] = 8'h02;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        mem_ready = 1'b1; sb_q.push_back(8'h02);
        tick();
        mem_ready = 1'b0;
        exp_ir = sb_q.pop_front();
        n_total++; if (ir !== exp_ir) $display("FAIL mid_pre_ir: got %h expected %h", ir, exp_ir); else n_pass++;
        exec_done = 1'b1; jump_taken = 1'b1; jump_addr = 8'h07;
        tick();
        exec_done = 1'b0; jump_taken = 1'b0;
        n_total++; if (mem_addr !== 8'h07 || mem_rd !== 1'b1) $display("FAIL mid_addr07: got addr=%h rd=%b expected addr=07 rd=1", mem_addr, mem_rd); else n_pass++;
        mem[8'h07] = 8'hEE;
        tick();
        rst = 1'b1; mem_ready = 1'b1;
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        n_total++; if (ir !== 8'h00 || pc !== 8'h00 || EN !== 1'b0) $display("FAIL mid_reset: got ir=%h pc=%h EN=%b expected ir=00 pc=00 EN=0", ir, pc, EN); else n_pass++;
        tick();
        n_total++; if (EN !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h00) $display("FAIL mid_refetch: got EN=%b rd=%b addr=%h expected EN=0 rd=1 addr=00", EN, mem_rd, mem_addr); else n_pass++;
        n_total++; if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; mem_ready = 1'b0; exec_done = 1'b0;
        jump_taken = 1'b0; jump_addr = 8'h00; HALT = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jump();
        test_halt_wrap();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
